// File: rtl/mem_stage_ctrl.sv
// Memory-access pipeline stage: drives the data-memory req/ack
// handshake and loads the MEM/WB register.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        RegWrite_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic        MemToReg_in,
  input  logic [1:0]  load_mode_in,
  input  logic [31:0] aluResult_in,
  input  logic [31:0] rt_in,
  input  logic [4:0]  writebackDestination_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [31:0] read_data_out,
  output logic [31:0] aluResult_out,
  output logic [4:0]  writebackDestination_out,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d, we_q, we_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             rw_q, rw_d, m2r_q, m2r_d, st_q, st_d;
  logic [1:0]       mode_q, mode_d, off_q, off_d;
  logic [31:0]      alu_q, alu_d;
  logic [4:0]       dst_q, dst_d;
  logic             wbv_q, wbv_d, rwo_q, rwo_d;
  logic             m2ro_q, m2ro_d;
  logic [31:0]      rdo_q, rdo_d, aluo_q, aluo_d;
  logic [4:0]       dsto_q, dsto_d;
  logic             aerr_q, aerr_d, berr_q, berr_d;

  logic        accept, is_mem, misalign;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ld_ext;
  logic [15:0] half_c;
  logic [7:0]  byte_c;

  assign in_ready = (state_q == S_IDLE) && reset_n;
  assign accept   = in_valid && in_ready;
  assign is_mem   = MemRead_in || MemWrite_in;

  always_comb begin
    misalign = 1'b0;
    be_c     = 4'b0001 << aluResult_in[1:0];
    wdata_c  = {4{rt_in[7:0]}};
    unique case (load_mode_in)
      2'b00: begin
        misalign = aluResult_in[1:0] != 2'b00;
        be_c     = 4'hF;
        wdata_c  = rt_in;
      end
      2'b01: begin
        misalign = aluResult_in[0];
        be_c     = aluResult_in[1] ? 4'hC : 4'h3;
        wdata_c  = {2{rt_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select uses the byte offset captured with the request.
  always_comb begin
    half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    byte_c = mem_rdata[7:0];
    unique case (off_q)
      2'd1:    byte_c = mem_rdata[15:8];
      2'd2:    byte_c = mem_rdata[23:16];
      2'd3:    byte_c = mem_rdata[31:24];
      default: ;
    endcase
    unique case (mode_q)
      2'b00:   ld_ext = mem_rdata;
      2'b01:   ld_ext = {{16{half_c[15]}}, half_c};
      2'b10:   ld_ext = {{24{byte_c[7]}}, byte_c};
      default: ld_ext = {24'd0, byte_c};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    m2r_d   = m2r_q;
    st_d    = st_q;
    mode_d  = mode_q;
    off_d   = off_q;
    alu_d   = alu_q;
    dst_d   = dst_q;
    wbv_d   = 1'b0;
    rwo_d   = rwo_q;
    m2ro_d  = m2ro_q;
    rdo_d   = rdo_q;
    aluo_d  = aluo_q;
    dsto_d  = dsto_q;
    aerr_d  = 1'b0;
    berr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept && (!is_mem || misalign)) begin
          wbv_d  = 1'b1;
          rwo_d  = RegWrite_in && !is_mem;
          m2ro_d = MemToReg_in;
          rdo_d  = 32'd0;
          aluo_d = aluResult_in;
          dsto_d = writebackDestination_in;
          aerr_d = is_mem;
        end else if (accept) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = MemWrite_in;
          addr_d  = {aluResult_in[31:2], 2'b00};
          be_d    = be_c;
          wdata_d = wdata_c;
          rw_d    = RegWrite_in;
          m2r_d   = MemToReg_in;
          st_d    = MemWrite_in;
          mode_d  = load_mode_in;
          off_d   = aluResult_in[1:0];
          alu_d   = aluResult_in;
          dst_d   = writebackDestination_in;
        end
      end
      S_WAIT: begin
        if (mem_ack || cnt_q == LAST) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wbv_d   = 1'b1;
          rwo_d   = rw_q && mem_ack;
          m2ro_d  = m2r_q;
          rdo_d   = (mem_ack && !st_q) ? ld_ext : 32'd0;
          aluo_d  = alu_q;
          dsto_d  = dst_q;
          berr_d  = !mem_ack;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      st_q    <= 1'b0;
      mode_q  <= 2'd0;
      off_q   <= 2'd0;
      alu_q   <= 32'd0;
      dst_q   <= 5'd0;
      wbv_q   <= 1'b0;
      rwo_q   <= 1'b0;
      m2ro_q  <= 1'b0;
      rdo_q   <= 32'd0;
      aluo_q  <= 32'd0;
      dsto_q  <= 5'd0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      st_q    <= st_d;
      mode_q  <= mode_d;
      off_q   <= off_d;
      alu_q   <= alu_d;
      dst_q   <= dst_d;
      wbv_q   <= wbv_d;
      rwo_q   <= rwo_d;
      m2ro_q  <= m2ro_d;
      rdo_q   <= rdo_d;
      aluo_q  <= aluo_d;
      dsto_q  <= dsto_d;
      aerr_q  <= aerr_d;
      berr_q  <= berr_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

  assign wb_valid                 = wbv_q;
  assign RegWrite_out             = rwo_q;
  assign MemToReg_out             = m2ro_q;
  assign read_data_out            = rdo_q;
  assign aluResult_out            = aluo_q;
  assign writebackDestination_out = dsto_q;
  assign align_err                = aerr_q;
  assign bus_err                  = berr_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: R-type stream, loads, store,
// misalignment, timeout and mid-access reset.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in;
  logic [1:0]  load_mode_in;
  logic [31:0] aluResult_in, rt_in;
  logic [4:0]  writebackDestination_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        wb_valid, RegWrite_out, MemToReg_out;
  logic [31:0] read_data_out, aluResult_out;
  logic [4:0]  writebackDestination_out;
  logic        align_err, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .RegWrite_in(RegWrite_in),
    .MemWrite_in(MemWrite_in),
    .MemRead_in(MemRead_in),
    .MemToReg_in(MemToReg_in),
    .load_mode_in(load_mode_in),
    .aluResult_in(aluResult_in),
    .rt_in(rt_in),
    .writebackDestination_in(writebackDestination_in),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_be(mem_be),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .wb_valid(wb_valid),
    .RegWrite_out(RegWrite_out),
    .MemToReg_out(MemToReg_out),
    .read_data_out(read_data_out),
    .aluResult_out(aluResult_out),
    .writebackDestination_out(writebackDestination_out),
    .align_err(align_err),
    .bus_err(bus_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic mw,
                       input logic mr, input logic m2r,
                       input logic [1:0] mode, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] dst);
    in_valid                = v;
    RegWrite_in             = rw;
    MemWrite_in             = mw;
    MemRead_in              = mr;
    MemToReg_in             = m2r;
    load_mode_in            = mode;
    aluResult_in            = alu;
    rt_in                   = rt;
    writebackDestination_in = dst;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mem_req, wb_valid, in_ready, align_err, bus_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b required 00000",
               {mem_req, wb_valid, in_ready, align_err, bus_err});
    end
    checks++;
    if (read_data_out !== 32'd0 || aluResult_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h required 0/0",
               read_data_out, aluResult_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    int seen_req;
    vals[0] = 32'h11;
    vals[1] = 32'h22;
    vals[2] = 32'h33;
    seen_req = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, vals[i], 32'd0,
            5'(i + 1));
      step();
      if (mem_req) seen_req++;
      checks++;
      if (wb_valid !== 1'b1 || aluResult_out !== vals[i] ||
          RegWrite_out !== 1'b1 || read_data_out !== 32'd0) begin
        errors++;
        $display("FAIL rtype_%0d: got v=%b alu=%h rw=%b rd=%h required 1 %h 1 0",
                 i, wb_valid, aluResult_out, RegWrite_out, read_data_out,
                 vals[i]);
      end
    end
    idle_in();
    step();
    if (mem_req) seen_req++;
    checks++;
    if (wb_valid !== 1'b0 || seen_req != 0) begin
      errors++;
      $display("FAIL rtype_end: got v=%b req_cycles=%0d required 0 0",
               wb_valid, seen_req);
    end
  endtask

  task automatic run_load(input string nm, input logic [1:0] mode,
                          input logic [31:0] addr, input logic [31:0] rd,
                          input logic [3:0] exp_be,
                          input logic [31:0] exp_rd);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, mode, addr, 32'd0, 5'd9);
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== exp_be ||
        mem_addr !== {addr[31:2], 2'b00} || in_ready !== 1'b0 ||
        wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_req: got req=%b we=%b be=%b a=%h rdy=%b v=%b required 1 0 %b %h 0 0",
               nm, mem_req, mem_we, mem_be, mem_addr, in_ready, wb_valid,
               exp_be, {addr[31:2], 2'b00});
    end
    idle_in();
    mem_rdata = rd;
    mem_ack   = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b1 || in_ready !== 1'b1 ||
        read_data_out !== exp_rd || RegWrite_out !== 1'b1 ||
        writebackDestination_out !== 5'd9) begin
      errors++;
      $display("FAIL %s_wb: got req=%b v=%b rdy=%b rd=%h rw=%b dst=%0d required 0 1 1 %h 1 9",
               nm, mem_req, wb_valid, in_ready, read_data_out,
               RegWrite_out, writebackDestination_out, exp_rd);
    end
  endtask

  task automatic test_loads();
    run_load("lb", 2'b10, 32'h1003, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80);
    run_load("lbu", 2'b11, 32'h1003, 32'h80FF_1234, 4'b1000, 32'h0000_0080);
    run_load("lh", 2'b01, 32'h1002, 32'h80FF_1234, 4'b1100, 32'hFFFF_80FF);
    run_load("lbu0", 2'b11, 32'h1000, 32'h80FF_1234, 4'b0001, 32'h0000_0034);
  endtask

  task automatic test_store();
    int low;
    int wbv;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'h2002, 32'hDEAD_BEEF,
          5'd0);
    step();
    low = in_ready ? 0 : 1;
    wbv = wb_valid ? 1 : 0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1100 ||
        mem_wdata !== 32'hBEEF_BEEF || mem_addr !== 32'h2000) begin
      errors++;
      $display("FAIL sh_req: got req=%b we=%b be=%b wd=%h a=%h required 1 1 1100 beefbeef 00002000",
               mem_req, mem_we, mem_be, mem_wdata, mem_addr);
    end
    idle_in();
    for (int i = 0; i < 3; i++) begin
      step();
      if (!in_ready) low++;
      if (wb_valid) wbv++;
    end
    checks++;
    if (mem_req !== 1'b1 || mem_wdata !== 32'hBEEF_BEEF ||
        mem_be !== 4'b1100) begin
      errors++;
      $display("FAIL sh_hold: got req=%b wd=%h be=%b required 1 beefbeef 1100",
               mem_req, mem_wdata, mem_be);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if (low != 4 || wbv != 0) begin
      errors++;
      $display("FAIL sh_stall: got low=%0d wbv=%0d required 4 0", low, wbv);
    end
    checks++;
    if (wb_valid !== 1'b1 || in_ready !== 1'b1 || mem_req !== 1'b0 ||
        read_data_out !== 32'd0 || RegWrite_out !== 1'b0) begin
      errors++;
      $display("FAIL sh_wb: got v=%b rdy=%b req=%b rd=%h rw=%b required 1 1 0 0 0",
               wb_valid, in_ready, mem_req, read_data_out, RegWrite_out);
    end
  endtask

  task automatic test_align();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h3001, 32'd0, 5'd7);
    step();
    checks++;
    if (align_err !== 1'b1 || mem_req !== 1'b0 || RegWrite_out !== 1'b0 ||
        wb_valid !== 1'b1 || in_ready !== 1'b1 ||
        aluResult_out !== 32'h3001) begin
      errors++;
      $display("FAIL align: got ae=%b req=%b rw=%b v=%b rdy=%b alu=%h required 1 0 0 1 1 00003001",
               align_err, mem_req, RegWrite_out, wb_valid, in_ready,
               aluResult_out);
    end
    idle_in();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if (align_err !== 1'b0 || wb_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack: got ae=%b v=%b req=%b required 0 0 0",
               align_err, wb_valid, mem_req);
    end
  endtask

  task automatic test_timeout();
    int reqs;
    reqs = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h4000, 32'd0, 5'd3);
    step();
    idle_in();
    while (mem_req && reqs < 40) begin
      reqs++;
      if (bus_err) break;
      step();
    end
    checks++;
    if (reqs != 16 || bus_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout: got reqs=%0d be=%b required 16 1",
               reqs, bus_err);
    end
    checks++;
    if (RegWrite_out !== 1'b0 || wb_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_wb: got rw=%b v=%b rdy=%b required 0 1 1",
               RegWrite_out, wb_valid, in_ready);
    end
    step();
    checks++;
    if (bus_err !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got be=%b v=%b required 0 0",
               bus_err, wb_valid);
    end
  endtask

  task automatic test_reset_wait();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h5000, 32'd0, 5'd4);
    step();
    idle_in();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got req=%b required 1", mem_req);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, wb_valid, in_ready} !== 4'b0 ||
        mem_addr !== 32'd0 || mem_be !== 4'd0 ||
        aluResult_out !== 32'd0) begin
      errors++;
      $display("FAIL rst_wait: got req=%b we=%b v=%b rdy=%b a=%h be=%b alu=%h required all 0",
               mem_req, mem_we, wb_valid, in_ready, mem_addr, mem_be,
               aluResult_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || mem_req !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: got rdy=%b req=%b v=%b required 1 0 0",
               in_ready, mem_req, wb_valid);
    end
    run_load("lw", 2'b00, 32'h5004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    idle_in();
    test_reset();
    test_back_to_back();
    test_loads();
    test_store();
    test_align();
    test_timeout();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
